timer_sequencer: RTL and testbench

Parametrised second-generation egg-timer controller. It owns the full set/run/alarm sequence: keypad edge detection, minute/second setting, tick-driven countdown with pause/resume, and a bounded alarm-flash phase that restores the programmed time. It sits between the debounced keypad and the seven-segment/LED display drivers, and replaces a state-only controller whose counting lived elsewhere.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/time_field_counter.sv | 38 +++
 rtl/timer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_timer_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the egg-timer controller: state encoding, key
// positions and the seconds limit.
package timer_pkg;

   // Encodings are fixed because the display drivers decode them directly.
   typedef enum logic [2:0] {
      SET_SEC   = 3'd0,
      SET_MIN   = 3'd1,
      RUN       = 3'd2,
      READY     = 3'd3,
      IDLE      = 3'd4,
      FLASH_ON  = 3'd5,
      FLASH_OFF = 3'd6,
      PAUSE     = 3'd7
   } state_t;

   // Bit positions within the active-low keypad bus.
   localparam int KEY_CLR = 0;
   localparam int KEY_SEL = 1;
   localparam int KEY_GO  = 2;
   localparam int KEY_INC = 3;

   localparam int SEC_MAX = 59;

endpackage

// File: rtl/time_field_counter.sv
// One time field (seconds or minutes): wrapping increment, decrement that
// wraps to MAX and flags a borrow, parallel load and clear.
module time_field_counter #(
   parameter int WIDTH = 6,
   parameter int MAX   = 59
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             borrow
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   // A decrement from zero asks the next-higher field to give up one unit.
   assign borrow = dec & (value == '0);

   // Field register: clear beats load, load beats inc, inc beats dec.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      if (reset || clr)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= (value == MAX_V) ? '0 : value + ONE;
      else if (dec)
         value <= (value == '0) ? MAX_V : value - ONE;
   end

endmodule

// File: rtl/timer_sequencer.sv
// Egg-timer controller: keypad edge detection, time setting, tick-driven
// countdown with pause, and a bounded alarm flash that restores the preset.
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int MIN_MAX     = 59,
   parameter int MIN_WIDTH   = 6,
   parameter int FLASH_COUNT = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic [3:0]           key,
   output logic [2:0]           state,
   output logic [MIN_WIDTH-1:0] min_out,
   output logic [5:0]           sec_out,
   output logic                 alarm,
   output logic                 done
);

   localparam int                FC_W       = $clog2(FLASH_COUNT + 1);
   localparam logic [FC_W-1:0]   FLASH_LAST = FC_W'(FLASH_COUNT - 1);

   state_t               state_r, state_next;
   logic [3:1]           key_q;       // clear is a level, so its history is not kept
   logic                 press_sel, press_go, press_inc;
   logic                 clear;
   logic [MIN_WIDTH-1:0] min_val, preset_min;
   logic [5:0]           sec_val, preset_sec;
   logic [FC_W-1:0]      fcnt;
   logic                 sec_inc, min_inc, sec_dec, sec_borrow, min_borrow_unused;
   logic                 restore, preset_load, fcnt_inc, fcnt_clr, done_next;
   logic                 last_second, time_zero;

   assign clear     = ~key[KEY_CLR];
   assign press_sel = ~key[KEY_SEL] & key_q[KEY_SEL];
   assign press_go  = ~key[KEY_GO]  & key_q[KEY_GO];
   assign press_inc = ~key[KEY_INC] & key_q[KEY_INC];

   assign time_zero   = (min_val == '0) && (sec_val == '0);
   assign last_second = (min_val == '0) && (sec_val == 6'd1);

   // Previous-cycle key sample for press detection; keeps sampling during clear.
   always_ff @(posedge clk) begin
      if (reset) key_q <= 3'b111;
      else       key_q <= key[3:1];
   end

   time_field_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
      .clk(clk), .reset(reset), .clr(clear), .load(restore), .load_val(preset_sec),
      .inc(sec_inc), .dec(sec_dec), .value(sec_val), .borrow(sec_borrow)
   );

   // Minutes count down only when seconds roll under; there is no hours field
   // to receive the minute borrow.
   time_field_counter #(.WIDTH(MIN_WIDTH), .MAX(MIN_MAX)) u_min (
      .clk(clk), .reset(reset), .clr(clear), .load(restore), .load_val(preset_min),
      .inc(min_inc), .dec(sec_borrow), .value(min_val), .borrow(min_borrow_unused)
   );

   // Next-state and control strobes; clear overrides every per-state action.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves it unassigned and infers a latch.
      state_next  = state_r;
      sec_inc     = 1'b0;
      min_inc     = 1'b0;
      sec_dec     = 1'b0;
      restore     = 1'b0;
      preset_load = 1'b0;
      fcnt_inc    = 1'b0;
      fcnt_clr    = 1'b0;
      done_next   = 1'b0;
      if (clear) begin
         state_next = IDLE;
      end else begin
         unique case (state_r)
            IDLE: state_next = SET_SEC;
            SET_SEC: begin
               sec_inc = press_inc;
               if (press_sel) state_next = SET_MIN;
            end
            SET_MIN: begin
               min_inc = press_inc;
               if (press_sel) state_next = READY;
            end
            READY: begin
               if (press_sel) begin
                  state_next = SET_SEC;
               end else if (press_go && !time_zero) begin
                  state_next  = RUN;
                  preset_load = 1'b1;
               end
            end
            RUN: begin
               sec_dec = tick;
               // Expiry on this tick outranks a simultaneous pause request.
               if (tick && last_second) begin
                  state_next = FLASH_ON;
                  done_next  = 1'b1;
               end else if (press_go) begin
                  state_next = PAUSE;
               end
            end
            PAUSE: if (press_go) state_next = RUN;
            FLASH_ON, FLASH_OFF: begin
               if (press_go) begin
                  state_next = READY;
                  restore    = 1'b1;
                  fcnt_clr   = 1'b1;
               end else if (tick && state_r == FLASH_ON) begin
                  state_next = FLASH_OFF;
               end else if (tick && fcnt == FLASH_LAST) begin
                  state_next = READY;
                  restore    = 1'b1;
                  fcnt_clr   = 1'b1;
               end else if (tick) begin
                  state_next = FLASH_ON;
                  fcnt_inc   = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State and done are registered so the display sees glitch-free values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         done    <= 1'b0;
      end else begin
         state_r <= state_next;
         done    <= done_next;
      end
   end

   // Preset captured at start so the alarm phase can restore the programmed time.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         preset_min <= '0;
         preset_sec <= '0;
      end else if (preset_load) begin
         preset_min <= min_val;
         preset_sec <= sec_val;
      end
   end

   // Counts completed FLASH_ON/FLASH_OFF pairs.
   always_ff @(posedge clk) begin
      if (reset || clear || fcnt_clr) fcnt <= '0;
      else if (fcnt_inc)              fcnt <= fcnt + FC_W'(1);
   end

   assign state   = state_r;
   assign min_out = min_val;
   assign sec_out = sec_val;
   assign alarm   = (state_r == FLASH_ON);

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios against fixed
// expectations plus a randomized run against a seconds-total reference model.
module tb_timer_sequencer;

   localparam int MIN_MAX     = 59;
   localparam int FLASH_COUNT = 2;

   localparam int ST_SET_SEC = 0, ST_SET_MIN = 1, ST_RUN = 2, ST_READY = 3;
   localparam int ST_IDLE = 4, ST_FLASH_ON = 5, ST_FLASH_OFF = 6, ST_PAUSE = 7;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [3:0] key;
   logic [2:0] state;
   logic [5:0] min_out;
   logic [5:0] sec_out;
   logic       alarm;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: time held as a total number of seconds, flash phase as
   // a count of ticks since the alarm started.
   int         m_st, m_total, m_preset, m_ftick;
   bit         m_done;
   logic [3:0] m_prev;

   timer_sequencer #(.MIN_MAX(MIN_MAX), .MIN_WIDTH(6), .FLASH_COUNT(FLASH_COUNT)) dut (
      .clk(clk), .reset(reset), .tick(tick), .key(key), .state(state),
      .min_out(min_out), .sec_out(sec_out), .alarm(alarm), .done(done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = ST_IDLE; m_total = 0; m_preset = 0; m_ftick = 0; m_done = 0;
      m_prev = 4'b1111;
   endtask

   task automatic model_edge(input logic [3:0] k, input logic t);
      logic [3:0] pr;
      int mn, sc;
      pr = ~k & m_prev;
      m_prev = k;
      m_done = 0;
      if (!k[0]) begin
         m_st = ST_IDLE; m_total = 0; m_preset = 0; m_ftick = 0;
         return;
      end
      mn = m_total / 60;
      sc = m_total % 60;
      case (m_st)
         ST_IDLE: m_st = ST_SET_SEC;
         ST_SET_SEC: begin
            if (pr[3]) m_total = mn * 60 + (sc + 1) % 60;
            if (pr[1]) m_st = ST_SET_MIN;
         end
         ST_SET_MIN: begin
            if (pr[3]) m_total = ((mn + 1) % (MIN_MAX + 1)) * 60 + sc;
            if (pr[1]) m_st = ST_READY;
         end
         ST_READY: begin
            if (pr[1]) m_st = ST_SET_SEC;
            else if (pr[2] && m_total != 0) begin
               m_preset = m_total;
               m_st = ST_RUN;
            end
         end
         ST_RUN: begin
            if (t) m_total = m_total - 1;
            if (t && m_total == 0) begin
               m_st = ST_FLASH_ON;
               m_done = 1;
            end else if (pr[2]) m_st = ST_PAUSE;
         end
         ST_PAUSE: if (pr[2]) m_st = ST_RUN;
         ST_FLASH_ON, ST_FLASH_OFF: begin
            if (pr[2]) begin
               m_st = ST_READY; m_total = m_preset; m_ftick = 0;
            end else if (t) begin
               m_ftick++;
               if (m_ftick == 2 * FLASH_COUNT) begin
                  m_st = ST_READY; m_total = m_preset; m_ftick = 0;
               end else begin
                  m_st = (m_ftick % 2 == 1) ? ST_FLASH_OFF : ST_FLASH_ON;
               end
            end
         end
         default: m_st = ST_IDLE;
      endcase
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic [3:0] k, input logic t);
      key  = k;
      tick = t;
      model_edge(k, t);
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int idx);
      logic [3:0] k;
      k = 4'b1111;
      k[idx] = 1'b0;
      step(k, 1'b0);
      step(4'b1111, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; key = 4'b1111; tick = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_checks++;
      if (state !== 3'd4 || min_out !== 6'd0 || sec_out !== 6'd0 || done !== 1'b0 || alarm !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: state=%0d min=%0d sec=%0d done=%0b alarm=%0b, expected 4 0 0 0 0",
                  state, min_out, sec_out, done, alarm);
      end
      step(4'b1111, 1'b0);
      n_checks++;
      if (state !== 3'd0 || sec_out !== 6'd0) begin
         n_errors++;
         $display("FAIL idle_to_set_sec: state=%0d sec=%0d, expected 0 0", state, sec_out);
      end
   endtask

   task automatic test_countdown();
      bit early;
      press(3); press(3);
      n_checks++;
      if (sec_out !== 6'd2) begin
         n_errors++; $display("FAIL set_sec: sec=%0d expected 2", sec_out);
      end
      press(1); press(3);
      n_checks++;
      if (state !== 3'd1 || min_out !== 6'd1) begin
         n_errors++; $display("FAIL set_min: state=%0d min=%0d expected 1 1", state, min_out);
      end
      press(1);
      step(4'b1011, 1'b0);
      n_checks++;
      if (state !== 3'd2) begin
         n_errors++; $display("FAIL go_to_run: state=%0d expected 2", state);
      end
      step(4'b1111, 1'b0);
      early = 0;
      for (int i = 0; i < 61; i++) begin
         step(4'b1111, 1'b1);
         if (done !== 1'b0 || state !== 3'd2) early = 1;
      end
      n_checks++;
      if (early || min_out !== 6'd0 || sec_out !== 6'd1) begin
         n_errors++;
         $display("FAIL countdown_61: early_exit=%0b min=%0d sec=%0d expected 0 0 1", early, min_out, sec_out);
      end
      step(4'b1111, 1'b1);
      n_checks++;
      if (done !== 1'b1 || state !== 3'd5 || alarm !== 1'b1 || min_out !== 6'd0 || sec_out !== 6'd0) begin
         n_errors++;
         $display("FAIL expiry: done=%0b state=%0d alarm=%0b min=%0d sec=%0d expected 1 5 1 0 0",
                  done, state, alarm, min_out, sec_out);
      end
      step(4'b1111, 1'b0);
      n_checks++;
      if (done !== 1'b0 || state !== 3'd5) begin
         n_errors++; $display("FAIL done_one_cycle: done=%0b state=%0d expected 0 5", done, state);
      end
   endtask

   task automatic test_flash_cycle();
      logic [2:0] exp_st [4] = '{3'd6, 3'd5, 3'd6, 3'd3};
      for (int i = 0; i < 4; i++) begin
         step(4'b1111, 1'b1);
         n_checks++;
         if (state !== exp_st[i] || alarm !== (exp_st[i] == 3'd5)) begin
            n_errors++;
            $display("FAIL flash_tick%0d: state=%0d alarm=%0b expected %0d", i, state, alarm, exp_st[i]);
         end
      end
      n_checks++;
      if (min_out !== 6'd1 || sec_out !== 6'd2) begin
         n_errors++; $display("FAIL flash_restore: min=%0d sec=%0d expected 1 2", min_out, sec_out);
      end
   endtask

   task automatic test_flash_ack();
      step(4'b1011, 1'b0);
      step(4'b1111, 1'b0);
      for (int i = 0; i < 62; i++) step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      n_checks++;
      if (state !== 3'd6) begin
         n_errors++; $display("FAIL flash_off_entry: state=%0d expected 6", state);
      end
      step(4'b1011, 1'b0);
      n_checks++;
      if (state !== 3'd3 || min_out !== 6'd1 || sec_out !== 6'd2) begin
         n_errors++;
         $display("FAIL flash_ack: state=%0d min=%0d sec=%0d expected 3 1 2", state, min_out, sec_out);
      end
      step(4'b1111, 1'b0);
   endtask

   task automatic test_pause();
      step(4'b1110, 1'b0);
      step(4'b1111, 1'b0);
      press(1); press(3); press(1);
      step(4'b1011, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      n_checks++;
      if (min_out !== 6'd0 || sec_out !== 6'd59) begin
         n_errors++; $display("FAIL borrow: min=%0d sec=%0d expected 0 59", min_out, sec_out);
      end
      step(4'b1011, 1'b0);
      n_checks++;
      if (state !== 3'd7) begin
         n_errors++; $display("FAIL pause: state=%0d expected 7", state);
      end
      step(4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b1111, 1'b1);
      n_checks++;
      if (state !== 3'd7 || min_out !== 6'd0 || sec_out !== 6'd59) begin
         n_errors++;
         $display("FAIL pause_hold: state=%0d min=%0d sec=%0d expected 7 0 59", state, min_out, sec_out);
      end
      step(4'b1011, 1'b0);
      n_checks++;
      if (state !== 3'd2) begin
         n_errors++; $display("FAIL resume: state=%0d expected 2", state);
      end
      step(4'b1111, 1'b0);
   endtask

   task automatic test_tie();
      step(4'b1110, 1'b0);
      step(4'b1111, 1'b0);
      press(3); press(1); press(1);
      step(4'b1011, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1011, 1'b1);
      n_checks++;
      if (state !== 3'd5 || done !== 1'b1 || sec_out !== 6'd0 || min_out !== 6'd0) begin
         n_errors++;
         $display("FAIL tick_go_tie: state=%0d done=%0b min=%0d sec=%0d expected 5 1 0 0",
                  state, done, min_out, sec_out);
      end
      step(4'b1111, 1'b0);
   endtask

   task automatic test_wraps();
      step(4'b1110, 1'b0);
      step(4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0111, 1'b0);
      step(4'b1111, 1'b0);
      n_checks++;
      if (sec_out !== 6'd1) begin
         n_errors++; $display("FAIL held_key: sec=%0d expected 1", sec_out);
      end
      for (int i = 0; i < 58; i++) press(3);
      n_checks++;
      if (sec_out !== 6'd59) begin
         n_errors++; $display("FAIL sec_max: sec=%0d expected 59", sec_out);
      end
      press(3);
      n_checks++;
      if (sec_out !== 6'd0) begin
         n_errors++; $display("FAIL sec_wrap: sec=%0d expected 0", sec_out);
      end
      press(1);
      for (int i = 0; i < MIN_MAX; i++) press(3);
      n_checks++;
      if (min_out !== 6'(MIN_MAX)) begin
         n_errors++; $display("FAIL min_max: min=%0d expected %0d", min_out, MIN_MAX);
      end
      press(3);
      n_checks++;
      if (min_out !== 6'd0) begin
         n_errors++; $display("FAIL min_wrap: min=%0d expected 0", min_out);
      end
      press(1);
      step(4'b1011, 1'b0);
      n_checks++;
      if (state !== 3'd3) begin
         n_errors++; $display("FAIL go_at_zero: state=%0d expected 3", state);
      end
      step(4'b1111, 1'b0);
   endtask

   task automatic test_clear_mid_run();
      press(1);
      for (int i = 0; i < 5; i++) press(3);
      press(1); press(1);
      step(4'b1011, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      n_checks++;
      if (state !== 3'd2 || sec_out !== 6'd4) begin
         n_errors++; $display("FAIL run_before_clear: state=%0d sec=%0d expected 2 4", state, sec_out);
      end
      step(4'b1110, 1'b1);
      n_checks++;
      if (state !== 3'd4 || min_out !== 6'd0 || sec_out !== 6'd0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL clear_mid_run: state=%0d min=%0d sec=%0d done=%0b expected 4 0 0 0",
                  state, min_out, sec_out, done);
      end
      step(4'b1111, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] k;
      logic       t;
      k = 4'b1111;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 1; b < 4; b++)
            if ($urandom_range(0, 3) == 0) k[b] = ~k[b];
         k[0] = ($urandom_range(0, 199) != 0);
         t = ($urandom_range(0, 2) == 0);
         step(k, t);
         n_checks++;
         if (state !== 3'(m_st) || min_out !== 6'(m_total / 60) || sec_out !== 6'(m_total % 60) ||
             done !== m_done || alarm !== (m_st == ST_FLASH_ON)) begin
            n_errors++;
            $display("FAIL random_cycle%0d: state=%0d min=%0d sec=%0d done=%0b alarm=%0b expected %0d %0d %0d %0b %0b",
                     c, state, min_out, sec_out, done, alarm,
                     m_st, m_total / 60, m_total % 60, m_done, m_st == ST_FLASH_ON);
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_flash_cycle();
      test_flash_ack();
      test_pause();
      test_tie();
      test_wraps();
      test_clear_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
